// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator delta feeder.
package acc_pkg;
    localparam int DW_DEFAULT       = 32;
    localparam int MAX_STEP_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        CLR  = 2'd2
    } state_t;
endpackage

// File: rtl/acc_step_clamp.sv
// Combinational step selection: modular delta between target and track,
// clamped to +/-MAX_STEP, with a flag telling whether this step lands on target.
module acc_step_clamp
    import acc_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_STEP = MAX_STEP_DEFAULT
) (
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] track,
    output logic [DW-1:0] step,
    output logic          is_final
);
    localparam logic [DW:0]   MAX_MAG  = (DW+1)'(MAX_STEP);
    localparam logic [DW-1:0] POS_STEP = DW'(MAX_STEP);
    localparam logic [DW-1:0] NEG_STEP = ~POS_STEP + 1'b1;

    logic signed [DW-1:0] delta;
    logic signed [DW:0]   delta_ext;
    logic        [DW:0]   mag;

    function automatic logic [DW-1:0] clamp_step(input logic signed [DW-1:0] d,
                                                 input logic                 fits);
        if (fits) begin
            return d;
        end else if (d[DW-1]) begin
            return NEG_STEP;
        end else begin
            return POS_STEP;
        end
    endfunction

    // One extra bit so that the most negative delta still has a positive magnitude.
    always_comb begin
        delta     = $signed(target - track);
        delta_ext = {delta[DW-1], delta};
        mag       = delta[DW-1] ? $unsigned(-delta_ext) : $unsigned(delta_ext);
        is_final  = (mag <= MAX_MAG);
        step      = clamp_step(delta, is_final);
    end
endmodule

// File: rtl/acc_delta_feeder.sv
// Turns absolute target samples into clamped signed deltas for the 32-bit acc.
// Optional statistics counters are enabled with the ACC_FEEDER_STATS_EN macro.
module acc_delta_feeder
    import acc_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_STEP = MAX_STEP_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          sync_req,
    output logic          acc_enable,
    output logic [DW-1:0] acc_data,
    output logic          acc_clr,
    output logic          busy,
    output logic [DW-1:0] track
`ifdef ACC_FEEDER_STATS_EN
    ,
    output logic [15:0]   stat_samples,
    output logic [15:0]   stat_pulses
`endif
);
    state_t        state_q, state_d;
    logic [DW-1:0] track_q, track_d;
    logic [DW-1:0] target_q, target_d;
    logic [DW-1:0] acc_data_q, acc_data_d;
    logic          acc_enable_q, acc_enable_d;
    logic          acc_clr_q, acc_clr_d;

    logic [DW-1:0] clamp_target;
    logic [DW-1:0] step;
    logic          step_final;
    logic          accept;

    assign in_ready     = (state_q == IDLE) && !sync_req;
    assign busy         = (state_q != IDLE);
    assign accept       = in_valid && in_ready;
    // In IDLE the incoming sample is the target; during a split the held one is.
    assign clamp_target = (state_q == IDLE) ? in_data : target_q;

    acc_step_clamp #(
        .DW       (DW),
        .MAX_STEP (MAX_STEP)
    ) u_clamp (
        .target   (clamp_target),
        .track    (track_q),
        .step     (step),
        .is_final (step_final)
    );

    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        target_d     = target_q;
        acc_enable_d = 1'b0;
        acc_data_d   = '0;
        acc_clr_d    = 1'b0;
        case (state_q)
            IDLE, STEP: begin
                if (sync_req) begin
                    state_d   = CLR;
                    track_d   = '0;
                    target_d  = '0;
                    acc_clr_d = 1'b1;
                end else if (state_q == STEP || accept) begin
                    target_d     = clamp_target;
                    acc_enable_d = |step;
                    acc_data_d   = step;
                    track_d      = track_q + step;
                    state_d      = step_final ? IDLE : STEP;
                end
            end
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            track_q      <= '0;
            target_q     <= '0;
            acc_enable_q <= 1'b0;
            acc_data_q   <= '0;
            acc_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            target_q     <= target_d;
            acc_enable_q <= acc_enable_d;
            acc_data_q   <= acc_data_d;
            acc_clr_q    <= acc_clr_d;
        end
    end

    assign acc_enable = acc_enable_q;
    assign acc_data   = acc_data_q;
    assign acc_clr    = acc_clr_q;
    assign track      = track_q;

`ifdef ACC_FEEDER_STATS_EN
    logic [15:0] stat_samples_q, stat_samples_d;
    logic [15:0] stat_pulses_q, stat_pulses_d;
    logic        enter_clr;

    always_comb begin
        enter_clr      = (state_d == CLR) && (state_q != CLR);
        stat_samples_d = stat_samples_q + 16'(accept);
        stat_pulses_d  = stat_pulses_q + 16'(acc_enable_q);
        if (enter_clr) begin
            stat_samples_d = '0;
            stat_pulses_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_samples_q <= '0;
            stat_pulses_q  <= '0;
        end else begin
            stat_samples_q <= stat_samples_d;
            stat_pulses_q  <= stat_pulses_d;
        end
    end

    assign stat_samples = stat_samples_q;
    assign stat_pulses  = stat_pulses_q;
`endif
endmodule
